bitmap_encoder_8x3: RTL and testbench
=====================================

// Module: bitmap_encoder_8x3
// PURPOSE
//   Reverse direction of the 3x8 one-hot decoder: accepts an 8-bit request
//   bitmap and serializes it into a stream of 3-bit indices, one per set bit,
//   in priority order. Sits between request-bitmap producers and
//   index-consuming logic. Both sides use a valid/ready handshake.
// PARAMETERS
//   LSB_FIRST  1  1: emit lowest set bit first; 0: emit highest set bit first
// PORTS
//   clk        in   1  single clock, all state on rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  in_bits valid
//   in_ready   out  1  block can accept a bitmap (high only in IDLE)
//   in_bits    in   8  request bitmap
//   out_valid  out  1  out_idx/out_last valid
//   out_ready  in   1  consumer accepts current index
//   out_idx    out  3  index of current highest-priority pending bit
//   out_last   out  1  current index is the final one of this bitmap
//   busy       out  1  high while in SCAN
// BEHAVIOUR
//   - State: 8-bit pend register + 1-bit FSM {IDLE, SCAN}.
//   - Reset (async, rst_n=0): pend=0, state=IDLE; immediately out_valid=0,
//     in_ready=1, busy=0, out_idx=0, out_last=0.
//   - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready with in_bits!=0:
//     pend<=in_bits, ->SCAN. With in_bits==0: bitmap consumed and dropped,
//     stay IDLE.
//   - SCAN: in_ready=0, out_valid=1, busy=1. out_idx = priority-encoded pend
//     (per LSB_FIRST); out_last=1 iff pend has exactly one bit set.
//     out_idx/out_last are combinational from pend only (no input paths).
//   - On out_valid&&out_ready: clear bit out_idx in pend; if out_last -> IDLE.
//   - Latency: bitmap accepted in cycle N -> first index valid cycle N+1.
//     Full throughput: popcount(in_bits) indices in consecutive cycles when
//     out_ready=1; next bitmap accepted the cycle after the last handshake.
//   - Backpressure: while out_valid&&!out_ready, out_idx/out_last/pend held.
//   - No overlap: in_valid ignored during SCAN (in_ready=0).
//   - Each set bit emitted exactly once; no index emitted for clear bits.
//   - Reset mid-SCAN: pending bits discarded, no further indices emitted.
// CONFIGURATION
//   ENC_ZERO_ERR_EN defined: adds output port err_zero (1 bit, reset 0);
//     registered one-cycle pulse in cycle N+1 when an all-zero bitmap is
//     accepted in cycle N. FSM otherwise unchanged.
//   ENC_ZERO_ERR_EN undefined: port absent; zero bitmaps silently dropped.
// TESTING
//   1. rst_n=0 mid-idle -> out_valid=0, in_ready=1, busy=0 without clk edge.
//   2. in_bits=8'h20, out_ready=1 -> next cycle out_idx=5, out_last=1;
//      cycle after: in_ready=1, out_valid=0.
//   3. LSB_FIRST=1, in_bits=8'hA5, out_ready=1 -> idx 0,2,5,7 on 4
//      consecutive cycles; out_last=1 only with idx 7.
//   4. LSB_FIRST=0, in_bits=8'hA5 -> idx 7,5,2,0; out_last only with 0.
//   5. in_bits=8'h81, out_ready=0 for 3 cycles -> idx 0 held stable,
//      in_valid pulses ignored; then out_ready=1 -> idx 0 then 7.
//   6. in_bits=8'hFF, assert rst_n after 3 handshakes -> out_valid drops
//      async; after release, in_bits=8'h01 -> single idx 0, out_last=1.
//   7. in_bits=8'h00 -> no out_valid, in_ready stays 1; with
//      ENC_ZERO_ERR_EN, err_zero=1 for exactly one cycle.

Source files
------------

// File: rtl/bitmap_encoder_8x3.sv
// Serializes an 8-bit request bitmap into a stream of 3-bit indices, one per set bit.
// Optional macro ENC_ZERO_ERR_EN adds the err_zero pulse output for accepted all-zero bitmaps.
module bitmap_encoder_8x3 #(
  parameter logic LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_bits,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic       busy
`ifdef ENC_ZERO_ERR_EN
  ,
  output logic       err_zero
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] pend_r;
  logic [7:0] pend_nxt_s;
  logic [2:0] idx_s;
  logic       last_s;
  logic       in_ready_s;
  logic       out_valid_s;

  function automatic logic [2:0] prio_enc(input logic [7:0] v, input logic lsb_first);
    logic [2:0] idx;
    idx = 3'd0;
    if (lsb_first) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) begin
          idx = 3'(i);
        end else begin
          idx = idx;
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          idx = 3'(i);
        end else begin
          idx = idx;
        end
      end
    end
    return idx;
  endfunction

  function automatic logic is_single_bit(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Index and last flag depend only on pending bits, so no input-to-output paths exist.
  assign idx_s       = prio_enc(pend_r, LSB_FIRST);
  assign last_s      = is_single_bit(pend_r);
  assign in_ready_s  = (state_r == IDLE);
  assign out_valid_s = (state_r == SCAN);

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign busy      = out_valid_s;
  assign out_idx   = idx_s;
  assign out_last  = last_s;

  // Next-state and pending-bit update.
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    case (state_r)
      IDLE: begin
        if (in_valid && (in_bits != 8'd0)) begin
          pend_nxt_s  = in_bits;
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pend_nxt_s = pend_r & ~(8'd1 << idx_s);
          if (last_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SCAN;
          end
        end else begin
          state_nxt_s = SCAN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pend_nxt_s  = 8'd0;
      end
    endcase
  end

  // State and pending-bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pend_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
    end
  end

`ifdef ENC_ZERO_ERR_EN
  logic zero_hit_s;
  logic err_zero_r;

  assign zero_hit_s = in_ready_s && in_valid && (in_bits == 8'd0);
  assign err_zero   = err_zero_r;

  // One-cycle pulse after an all-zero bitmap is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_zero_r <= 1'b0;
    end else begin
      err_zero_r <= zero_hit_s;
    end
  end
`endif

endmodule

// File: tb/tb_bitmap_encoder_8x3.sv
// Bench for bitmap_encoder_8x3: both priority orders side by side against a queue-based model.
module tb_bitmap_encoder_8x3;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_bits;
  logic       out_ready;

  logic       l_in_ready, l_out_valid, l_out_last, l_busy;
  logic [2:0] l_out_idx;
  logic       m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [2:0] m_out_idx;
`ifdef ENC_ZERO_ERR_EN
  logic       l_err_zero, m_err_zero;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0] ql[$];
  logic [2:0] qm[$];
  logic       exp_err;

  bitmap_encoder_8x3 #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_bits(in_bits), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_idx(l_out_idx), .out_last(l_out_last), .busy(l_busy)
`ifdef ENC_ZERO_ERR_EN
    , .err_zero(l_err_zero)
`endif
  );

  bitmap_encoder_8x3 #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_bits(in_bits), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_idx(m_out_idx), .out_last(m_out_last), .busy(m_busy)
`ifdef ENC_ZERO_ERR_EN
    , .err_zero(m_err_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2:0] el, em;
    el = (ql.size() != 0) ? ql[0] : 3'd0;
    em = (qm.size() != 0) ? qm[0] : 3'd0;
    chk("l_out_valid", {7'd0, l_out_valid}, {7'd0, ql.size() != 0});
    chk("l_in_ready",  {7'd0, l_in_ready},  {7'd0, ql.size() == 0});
    chk("l_busy",      {7'd0, l_busy},      {7'd0, ql.size() != 0});
    chk("l_out_idx",   {5'd0, l_out_idx},   {5'd0, el});
    chk("l_out_last",  {7'd0, l_out_last},  {7'd0, ql.size() == 1});
    chk("m_out_valid", {7'd0, m_out_valid}, {7'd0, qm.size() != 0});
    chk("m_in_ready",  {7'd0, m_in_ready},  {7'd0, qm.size() == 0});
    chk("m_busy",      {7'd0, m_busy},      {7'd0, qm.size() != 0});
    chk("m_out_idx",   {5'd0, m_out_idx},   {5'd0, em});
    chk("m_out_last",  {7'd0, m_out_last},  {7'd0, qm.size() == 1});
`ifdef ENC_ZERO_ERR_EN
    chk("l_err_zero", {7'd0, l_err_zero}, {7'd0, exp_err});
    chk("m_err_zero", {7'd0, m_err_zero}, {7'd0, exp_err});
`endif
  endtask

  // Check current outputs, apply inputs, advance the model, then move to the next falling edge.
  task automatic step(input logic iv, input logic [7:0] bits, input logic ordy);
    check_outputs();
    in_valid  = iv;
    in_bits   = bits;
    out_ready = ordy;
    exp_err   = 1'b0;
    if (ql.size() == 0) begin
      if (iv) begin
        if (bits != 8'd0) begin
          for (int i = 0; i < 8; i++) if (bits[i]) ql.push_back(3'(i));
          for (int i = 7; i >= 0; i--) if (bits[i]) qm.push_back(3'(i));
        end else begin
          exp_err = 1'b1;
        end
      end
    end else if (ordy) begin
      void'(ql.pop_front());
      void'(qm.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_l_out_valid"}, {7'd0, l_out_valid}, 8'd0);
    chk({tag, "_l_in_ready"},  {7'd0, l_in_ready},  8'd1);
    chk({tag, "_l_busy"},      {7'd0, l_busy},      8'd0);
    chk({tag, "_l_out_idx"},   {5'd0, l_out_idx},   8'd0);
    chk({tag, "_l_out_last"},  {7'd0, l_out_last},  8'd0);
    chk({tag, "_m_out_valid"}, {7'd0, m_out_valid}, 8'd0);
    chk({tag, "_m_in_ready"},  {7'd0, m_in_ready},  8'd1);
    chk({tag, "_m_out_idx"},   {5'd0, m_out_idx},   8'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bits   = 8'd0;
    out_ready = 1'b0;
    exp_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'd0, 1'b1);

    // Asynchronous reset while idle, checked before any rising edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_idle");
    @(negedge clk);
    rst_n = 1'b1;

    // Single bit.
    step(1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Multi-bit bitmap at full throughput.
    step(1'b1, 8'hA5, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Backpressure with ignored in_valid pulses.
    step(1'b1, 8'h81, 1'b1);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h7E, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a scan.
    step(1'b1, 8'hFF, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    check_outputs();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_scan");
    ql.delete();
    qm.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h01, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // All-zero bitmap is dropped.
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Back-to-back bitmaps with in_valid held.
    step(1'b1, 8'h06, 1'b1);
    step(1'b1, 8'h18, 1'b1);
    step(1'b1, 8'h18, 1'b1);
    step(1'b1, 8'h18, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b = 8'd0;
      step(1'($urandom_range(0, 1)), b, ($urandom_range(0, 3) != 0));
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
